// File: rtl/reaction_game_ctrl.sv
// Reaction-time game sequencer: random pre-stimulus delay, BCD ms reaction count, false-start and timeout detection.
// Optional best-time tracking is enabled with `define REACTION_BEST_TIME_EN.
module reaction_game_ctrl #(
  parameter int MIN_DELAY_MS  = 1000,
  parameter int DELAY_STEP_MS = 250,
  parameter int MAX_REACT_MS  = 9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_1ms,
  input  logic        start,
  input  logic        react,
  input  logic [3:0]  rand_val,
  output logic        stim_led,
  output logic [15:0] time_bcd,
  output logic [2:0]  state_o,
  output logic        foul,
  output logic        timeout,
  output logic        done
`ifdef REACTION_BEST_TIME_EN
  ,
  output logic [15:0] best_bcd,
  output logic        new_best
`endif
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARM     = 3'd1;
  localparam logic [2:0] S_STIM    = 3'd2;
  localparam logic [2:0] S_RESULT  = 3'd3;
  localparam logic [2:0] S_FOUL    = 3'd4;
  localparam logic [2:0] S_TIMEOUT = 3'd5;

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  // Ripple a +1 through four decimal digits, wrapping each 9 to 0 with carry.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  localparam logic [15:0] MAX_BCD = to_bcd(MAX_REACT_MS);

  logic [2:0]  state;
  logic [31:0] delay_cnt;
  logic [31:0] delay_load;

  assign state_o    = state;
  assign delay_load = 32'(MIN_DELAY_MS) + 32'(rand_val) * 32'(DELAY_STEP_MS);

  // NOTE: all state, including the delay counter, sits under the async reset so a mid-round reset leaves nothing stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      delay_cnt <= '0;
      stim_led  <= 1'b0;
      time_bcd  <= 16'h0000;
      foul      <= 1'b0;
      timeout   <= 1'b0;
      done      <= 1'b0;
`ifdef REACTION_BEST_TIME_EN
      best_bcd  <= 16'h9999;
      new_best  <= 1'b0;
`endif
    end else begin
      // NOTE: pulses default low every cycle and are raised only on the entry edge, so they last exactly one clk.
      done <= 1'b0;
`ifdef REACTION_BEST_TIME_EN
      new_best <= 1'b0;
`endif
      case (state)
        S_IDLE, S_RESULT, S_FOUL, S_TIMEOUT: begin
          if (start) begin
            state     <= S_ARM;
            delay_cnt <= delay_load;
            time_bcd  <= 16'h0000;
            foul      <= 1'b0;
            timeout   <= 1'b0;
          end
        end
        S_ARM: begin
          if (react) begin
            state <= S_FOUL;
            foul  <= 1'b1;
            done  <= 1'b1;
          end else if (tick_1ms) begin
            // A zero-length delay expires on the first tick, same as a count of 1.
            if (delay_cnt <= 32'd1) begin
              state     <= S_STIM;
              stim_led  <= 1'b1;
              delay_cnt <= '0;
            end else begin
              delay_cnt <= delay_cnt - 32'd1;
            end
          end
        end
        S_STIM: begin
          if (react) begin
            state    <= S_RESULT;
            stim_led <= 1'b0;
            done     <= 1'b1;
`ifdef REACTION_BEST_TIME_EN
            // BCD digit order matches magnitude order, so a plain unsigned compare is valid.
            if (time_bcd < best_bcd) begin
              best_bcd <= time_bcd;
              new_best <= 1'b1;
            end
`endif
          end else if (tick_1ms) begin
            if (time_bcd == MAX_BCD) begin
              state    <= S_TIMEOUT;
              timeout  <= 1'b1;
              stim_led <= 1'b0;
              done     <= 1'b1;
            end else begin
              time_bcd <= bcd_inc(time_bcd);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
